// File: rtl/id_digit_matcher.sv
// Streaming matcher for the 16-digit team ID: tracks the matched-prefix length
// with exact overlapping search, and pulses/counts on every complete occurrence.
module id_digit_matcher #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               digit_valid,
    input  logic [3:0]         digit,
    output logic [3:0]         pos,
    output logic [3:0]         expect_digit,
    output logic               match,
    output logic [COUNT_W-1:0] match_count,
    output logic               busy
);

    function automatic logic [3:0] id_at(input logic [3:0] idx);
        logic [3:0] d;
        unique case (idx)
            4'd0:    d = 4'hA;
            4'd1:    d = 4'hA;
            4'd2:    d = 4'hC;
            4'd3:    d = 4'h0;
            4'd4:    d = 4'hF;
            4'd5:    d = 4'hF;
            4'd6:    d = 4'hE;
            4'd7:    d = 4'hE;
            4'd8:    d = 4'hA;
            4'd9:    d = 4'h1;
            4'd10:   d = 4'h5;
            4'd11:   d = 4'hA;
            4'd12:   d = 4'h9;
            4'd13:   d = 4'h0;
            4'd14:   d = 4'h0;
            default: d = 4'hD;
        endcase
        return d;
    endfunction

    logic [3:0]         pos_q, pos_d;
    logic               match_q, match_d;
    logic [COUNT_W-1:0] count_q, count_d;

    always_comb begin
        pos_d   = pos_q;
        match_d = 1'b0;
        count_d = count_q;
        if (digit_valid) begin
            if (digit == id_at(pos_q)) begin
                if (pos_q == 4'd15) begin
                    pos_d   = 4'd0;
                    match_d = 1'b1;
                    if (count_q != {COUNT_W{1'b1}}) begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    pos_d = pos_q + 4'd1;
                end
            end else if (digit == 4'hA) begin
                // Received tail is "AA" exactly when the last matched digit was an A.
                if (pos_q != 4'd0 && id_at(pos_q - 4'd1) == 4'hA) begin
                    pos_d = 4'd2;
                end else begin
                    pos_d = 4'd1;
                end
            end else begin
                pos_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pos_q   <= 4'd0;
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            pos_q   <= pos_d;
            match_q <= match_d;
            count_q <= count_d;
        end
    end

    assign pos          = pos_q;
    assign expect_digit = id_at(pos_q);
    assign match        = match_q;
    assign match_count  = count_q;
    assign busy         = (pos_q != 4'd0);

endmodule

// File: tb/tb_id_digit_matcher.sv
// Bench for id_digit_matcher: a suffix/prefix string model checked every cycle
// on two instances (8-bit and 2-bit counters) plus directed literal checks.
module tb_id_digit_matcher;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'h0;

    logic [3:0] pos8, exp8, pos2, exp2;
    logic       match8, match2, busy8, busy2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    id_digit_matcher #(.COUNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .clear(clear), .digit_valid(digit_valid), .digit(digit),
        .pos(pos8), .expect_digit(exp8), .match(match8), .match_count(cnt8), .busy(busy8)
    );

    id_digit_matcher #(.COUNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .digit_valid(digit_valid), .digit(digit),
        .pos(pos2), .expect_digit(exp2), .match(match2), .match_count(cnt2), .busy(busy2)
    );

    always #5 clk = ~clk;

    logic [3:0] id_tab [16] = '{4'hA, 4'hA, 4'hC, 4'h0, 4'hF, 4'hF, 4'hE, 4'hE,
                                4'hA, 4'h1, 4'h5, 4'hA, 4'h9, 4'h0, 4'h0, 4'hD};

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of received digits (newest in the low nibble); pos is the
    // longest suffix of the history, shorter than 16, that is a prefix of the ID.
    function automatic bit suffix_is_prefix(input logic [63:0] h, input int n, input int len);
        if (len > n) return 1'b0;
        for (int k = 0; k < len; k++) begin
            if (h[4*(len-1-k) +: 4] != id_tab[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int best_prefix(input logic [63:0] h, input int n);
        for (int len = 15; len >= 1; len--) begin
            if (suffix_is_prefix(h, n, len)) return len;
        end
        return 0;
    endfunction

    logic [63:0] hist = '0;
    int          hlen = 0;
    int          mpos = 0;
    bit          mmatch = 1'b0;
    int          mc8 = 0;
    int          mc2 = 0;

    always @(posedge clk) begin
        if (rst || clear) begin
            hist   <= '0;
            hlen   <= 0;
            mpos   <= 0;
            mmatch <= 1'b0;
            mc8    <= 0;
            mc2    <= 0;
        end else if (digit_valid) begin
            hist   <= {hist[59:0], digit};
            hlen   <= (hlen < 16) ? hlen + 1 : 16;
            mpos   <= best_prefix({hist[59:0], digit}, (hlen < 16) ? hlen + 1 : 16);
            mmatch <= suffix_is_prefix({hist[59:0], digit}, (hlen < 16) ? hlen + 1 : 16, 16);
            if (suffix_is_prefix({hist[59:0], digit}, (hlen < 16) ? hlen + 1 : 16, 16)) begin
                mc8 <= (mc8 < 255) ? mc8 + 1 : mc8;
                mc2 <= (mc2 < 3) ? mc2 + 1 : mc2;
            end
        end else begin
            mmatch <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pos8", int'(pos8), mpos);
            check("expect8", int'(exp8), int'(id_tab[mpos]));
            check("match8", int'(match8), int'(mmatch));
            check("count8", int'(cnt8), mc8);
            check("busy8", int'(busy8), int'(mpos != 0));
            check("pos2", int'(pos2), mpos);
            check("expect2", int'(exp2), int'(id_tab[mpos]));
            check("match2", int'(match2), int'(mmatch));
            check("count2", int'(cnt2), mc2);
            check("busy2", int'(busy2), int'(mpos != 0));
        end
    end

    task automatic step(input bit v, input logic [3:0] d, input bit r = 1'b0,
                        input bit c = 1'b0);
        rst         = r;
        clear       = c;
        digit_valid = v;
        digit       = d;
        @(negedge clk);
    endtask

    task automatic send_seq(input logic [3:0] s [], input int n);
        for (int i = 0; i < n; i++) step(1'b1, s[i]);
    endtask

    int pulses;
    int exp_cnt [5] = '{1, 2, 3, 3, 3};

    initial begin
        logic [3:0] seq [];

        // Reset held two cycles while a valid A is presented.
        step(1'b1, 4'hA, 1'b1);
        step(1'b1, 4'hA, 1'b1);
        chk_en = 1'b1;
        check("rst_pos", int'(pos8), 0);
        check("rst_expect", int'(exp8), 10);
        check("rst_match", int'(match8), 0);
        check("rst_count", int'(cnt8), 0);
        check("rst_busy", int'(busy8), 0);

        // Single back-to-back match.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, id_tab[i]);
            check("single_pos", int'(pos8), (i == 15) ? 0 : i + 1);
        end
        check("single_match", int'(match8), 1);
        check("single_count", int'(cnt8), 1);
        step(1'b0, 4'h0);
        check("single_pulse_end", int'(match8), 0);

        // False start: AAA then remainder of the ID.
        seq = '{4'hA, 4'hA, 4'hA};
        send_seq(seq, 3);
        check("false_aaa_pos", int'(pos8), 2);
        for (int i = 2; i < 16; i++) step(1'b1, id_tab[i]);
        check("false_match", int'(match8), 1);
        check("false_count", int'(cnt8), 2);
        seq = '{4'hA, 4'hA, 4'hC, 4'h0, 4'hF, 4'hF, 4'hE, 4'hE, 4'hA};
        send_seq(seq, 9);
        check("overlap_pos9", int'(pos8), 9);
        step(1'b1, 4'hA);
        check("overlap_pos2", int'(pos8), 2);

        // Gaps of three idle cycles between digits.
        step(1'b0, 4'h0, 1'b0, 1'b1);
        check("clear_count", int'(cnt8), 0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, id_tab[i]);
            if (i == 15) check("gap_match", int'(match8), 1);
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 4'hA);
                check("gap_pos", int'(pos8), (i == 15) ? 0 : i + 1);
            end
        end
        check("gap_count", int'(cnt8), 1);

        // Clear in the same cycle as a valid digit discards the digit.
        for (int i = 0; i < 8; i++) step(1'b1, id_tab[i]);
        check("pre_clear_pos", int'(pos8), 8);
        step(1'b1, 4'hA, 1'b0, 1'b1);
        check("clear_pos", int'(pos8), 0);
        check("clear_count2", int'(cnt8), 0);
        check("clear_busy", int'(busy8), 0);
        step(1'b0, 4'h0);
        check("clear_nopulse", int'(match8), 0);

        // Mismatch on a non-A digit drops to zero.
        seq = '{4'hA, 4'hA, 4'hC, 4'h7};
        send_seq(seq, 4);
        check("mis_pos", int'(pos8), 0);
        check("mis_busy", int'(busy8), 0);
        step(1'b1, 4'hA);
        check("mis_restart", int'(pos8), 1);

        // Saturation on the 2-bit counter over five back-to-back IDs.
        step(1'b0, 4'h0, 1'b0, 1'b1);
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 16; i++) begin
                step(1'b1, id_tab[i]);
                if (match2) pulses++;
            end
            check("sat_match", int'(match2), 1);
            check("sat_count", int'(cnt2), exp_cnt[r]);
        end
        step(1'b0, 4'h0);
        if (match2) pulses++;
        check("sat_pulses", pulses, 5);
        check("sat_count8", int'(cnt8), 5);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_digit_matcher.md
Name: id_digit_matcher

Overview:
- Receives a stream of 4-bit hex digits and searches it for the 16-digit team ID sequence A A C 0 F F E E A 1 5 A 9 0 0 D (index 0 to 15).
- The ID lookup block produces this sequence from an index. This block is the other direction: it recovers the index, meaning the matched-prefix length, from the digits.
- It reports progress, the next expected digit, a match pulse and a saturating match count.
- It sits between a switch/keypad digit source and the 7-segment/LED display logic.

Parameters:
- COUNT_W, 8, width of the match counter. Range is 1 to 16.

Ports:
- clk, input, 1, system clock. All logic is rising-edge.
- rst, input, 1, synchronous, active-high reset.
- clear, input, 1, synchronous, active-high. Same effect as rst.
- digit_valid, input, 1, qualifies digit for one clock.
- digit, input, 4, incoming hex digit.
- pos, output, 4, current matched-prefix length, 0 to 15.
- expect_digit, output, 4, the ID digit at index pos (combinational from pos).
- match, output, 1, one-cycle pulse when the full 16-digit ID has been received.
- match_count, output, COUNT_W, number of matches. Saturates at all-ones.
- busy, output, 1, high when pos != 0.

Behaviour:
- Reset and clear:
  - On rst or clear at a rising edge: pos=0, match=0, match_count=0.
  - This gives expect_digit=4'hA and busy=0.
  - rst/clear take priority over digit_valid in the same cycle. The digit is discarded.
  - Reset mid-sequence abandons the partial match and emits no pulse.
- digit_valid low: pos and match_count hold, and match=0 on the next cycle.
- Storage: the ID table is internal constant logic. No RAM.
- Accepting a digit (digit_valid=1 at edge):
  - Match, pos<15 (digit==ID[pos]): pos <= pos+1, match <= 0.
  - Match, pos==15 (digit==4'hD):
    - pos <= 0.
    - match <= 1 for exactly the next cycle.
    - match_count <= match_count+1, unless already all-ones, in which case it holds.
    - No prefix of the ID ends in D, so restarting at 0 is the exact overlap behaviour.
  - Mismatch with digit==4'hA:
    - pos <= 2 if ID[pos-1]==A for pos ∈ {2,9,12}. The received tail is then "AA".
    - Otherwise pos <= 1.
    - pos==1 never mismatches on A.
  - Mismatch with any other digit: pos <= 0, because every ID prefix starts with A.
  - These rules implement exact overlapping search. Any occurrence of the ID in the stream is detected, including after false starts such as "AAAC…".
- Latency: match is registered. It is high in the cycle after the edge that accepted the final D.
- Back-to-back operation:
  - Valid digits may arrive on every cycle.
  - Two consecutive complete IDs produce two pulses 16 cycles apart.
- Gaps: digit_valid may drop for any number of cycles mid-sequence without affecting pos.
- Sizing: pos is 4 bits and never wraps, because the 15→0 transition only happens on a match or mismatch.
- match_count never wraps.

Test Plan:
1. Reset behaviour: assert rst for 2 cycles while digit_valid=1, digit=A → pos=0, expect_digit=A, match=0, match_count=0, busy=0.
2. Single match: feed A,A,C,0,F,F,E,E,A,1,5,A,9,0,0,D on 16 consecutive cycles → pos steps 1..15 then 0. match=1 for exactly one cycle, the cycle after D. match_count=1.
3. False-start recovery:
   - Feed A,A,A,C,0,F,F,E,E,A,1,5,A,9,0,0,D → one match pulse. After the third A, pos=2.
   - Then feed A,A,C,0,F,F,E,E,A,A → pos=2 after the final A.
4. Gaps and clear:
   - Feed the ID with digit_valid low for 3 cycles between each digit → one pulse, pos holds during gaps.
   - Feed 8 correct digits, then assert clear together with digit_valid, digit=A → pos=0, match_count=0, no pulse.
5. Mismatch to zero: after A,A,C, feed 7 → pos=0, busy=0. The next A gives pos=1.
6. Saturation: with COUNT_W=2, feed the ID 5 times back-to-back → 5 match pulses, match_count reads 1,2,3,3,3.
